fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one FIFO instance (DATA_WIDTH=32, FIFO_DEPTH=8) between NUM_REQ producers.
- Each producer offers packets on a valid/ready/last interface.
- The arbiter locks a grant for one burst, ending on packet end, beat limit or idle timeout, then rotates priority.
- It drives the FIFO's cs/wr_en/din and obeys its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, beat width; must match the FIFO's DATA_WIDTH
- MAX_BURST, 4, maximum beats per grant (1..16)
- IDLE_TIMEOUT, 8, consecutive cycles with the granted valid low before the grant is released (1..255)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_last  input  NUM_REQ  per-requester last beat of packet
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- fifo_full  input  1  full flag from the FIFO
- fifo_cs  output  1  FIFO chip select
- fifo_wr_en  output  1  FIFO write enable
- fifo_din  output  DATA_WIDTH  FIFO write data
- grant_id  output  $clog2(NUM_REQ)  current/last granted requester
- busy  output  1  high while in BURST

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, idle_cnt=0.
  - req_ready=0, fifo_wr_en=0, fifo_cs=0, busy=0.
  - fifo_din = req_data slice of grant_id (slice 0).
  - Reset mid-burst abandons the burst; no partial-state recovery.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid, pick the first valid requester searching from rr_ptr upward with wrap-around.
  - Register it into grant_id and enter BURST next cycle. This is 1 cycle of arbitration latency; no beat is accepted in IDLE.
  - If no req_valid, stay in IDLE.
- BURST (combinational outputs):
  - req_ready[grant_id] = !fifo_full.
  - fifo_wr_en = req_valid[grant_id] && !fifo_full.
  - fifo_cs = busy.
  - fifo_din = req_data slice of grant_id.
  - A beat is accepted when fifo_wr_en=1; beat_cnt then increments and idle_cnt clears.
- Burst end (goes to IDLE next cycle, rr_ptr <= grant_id+1 mod NUM_REQ, beat_cnt/idle_cnt cleared) on any of:
  - (a) accepted beat with req_last[grant_id]=1
  - (b) accepted beat making beat_cnt == MAX_BURST
  - (c) idle_cnt reaching IDLE_TIMEOUT
- idle_cnt:
  - Increments only when req_valid[grant_id]=0.
  - Holds (no increment) when valid=1 but fifo_full=1; back-pressure never times out a grant.
- Packets longer than MAX_BURST are split; the requester is re-arbitrated normally for the remainder, and req_last stays with the packet's final beat.
- Non-granted requesters always see req_ready=0; their valid/data must stay stable until accepted.
- fifo_full=1 on the cycle of the final beat: the beat is not accepted, the burst does not end, and the grant is held until full drops.
- The FIFO's read side is not touched.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - idle_cnt is 8 bits and saturates at IDLE_TIMEOUT.
  - rr_ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.
- Throughput:
  - Max NUM_REQ*MAX_BURST… per rotation; one bubble (IDLE) cycle between bursts.
  - Steady state is MAX_BURST/(MAX_BURST+1) beats per cycle.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST}
  - REQ_IDX_W = $clog2(NUM_REQ) and BEAT_CNT_W helper functions
  - the idle_cnt width constant
- One combinational sub-module, rr_pick:
  - Inputs: req vector, rr_ptr.
  - Outputs: found flag, winner index.
  - Unit-tested standalone.
- FSM, counters and muxing stay in fifo_wr_arbiter.

Test Plan:
- Reset/idle: rst low for 3 cycles, all req_valid=0 → after release busy=0, fifo_wr_en=0, req_ready=0, grant_id=0 for 10 cycles.
- Round-robin fairness: all 4 valid, 1-beat packets (last=1), fifo_full=0 → FIFO writes come from requesters 0,1,2,3,0,1, one write every 2 cycles.
- Burst split: requester 2 alone sends a 6-beat packet with data 0x20..0x25 → writes 0x20..0x23, one IDLE cycle, then 0x24..0x25; busy drops after 0x25; rr_ptr=3.
- Back-pressure: mid-burst, fifo_full held high for 5 cycles with valid high → no write, req_ready=0, grant held, no timeout; burst resumes when full drops and data order is preserved.
- Idle timeout: requester 1 granted, sends 1 beat (last=0), then drops valid → release exactly 8 cycles later; requester 3 (valid) is granted next; requester 1 is served after 3.
- Async reset mid-burst: rst asserted between clock edges while beat_cnt=2 → req_ready/fifo_wr_en go 0 immediately; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int IDLE_CNT_W = 8;

  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_cnt_w(input int mb);
    return $clog2(mb + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of i_req at or above i_ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int w_j;

  // Scan offsets high to low so the smallest offset from i_ptr wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % N;
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [req_idx_w(NUM_REQ)-1:0] grant_id,
  output logic                          busy
);

  localparam int IW = req_idx_w(NUM_REQ);
  localparam int BW = beat_cnt_w(MAX_BURST);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IDLE_CNT_W-1:0] TMO =
    IDLE_CNT_W'(IDLE_TIMEOUT);

  arb_state_e            r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_gid;
  logic [BW-1:0]         r_beat;
  logic [IDLE_CNT_W-1:0] r_idle;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic          w_busy;
  logic          w_vld;
  logic          w_lst;
  logic          w_acc;
  logic          w_tmo;
  logic          w_end;
  logic [BW-1:0] w_beat_nx;
  logic [IW-1:0] w_ptr_nx;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  assign w_busy    = (r_state == ST_BURST);
  assign w_vld     = req_valid[r_gid];
  assign w_lst     = req_last[r_gid];
  assign w_acc     = w_busy && w_vld && !fifo_full;
  assign w_beat_nx = r_beat + 1'b1;
  assign w_ptr_nx  = (r_gid == LAST_ID) ? '0 : r_gid + 1'b1;

  // Only a low valid ages the grant; back-pressure never does.
  assign w_tmo = !w_vld && (r_idle + 1'b1 == TMO);
  assign w_end = w_busy &&
    ((w_acc && (w_lst || w_beat_nx == BURST_MAX)) || w_tmo);

  always_comb begin
    req_ready = '0;
    if (w_busy && !fifo_full)
      req_ready[r_gid] = 1'b1;
  end

  assign fifo_wr_en = w_acc;
  assign fifo_cs    = w_busy;
  assign fifo_din   = req_data[r_gid*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id   = r_gid;
  assign busy       = w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_beat  <= '0;
      r_idle  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gid   <= w_win;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_end) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_ptr_nx;
            r_beat  <= '0;
            r_idle  <= '0;
          end else if (w_acc) begin
            r_beat <= w_beat_nx;
            r_idle <= '0;
          end else if (!w_vld && r_idle != TMO) begin
            r_idle <= r_idle + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
